star_result_writer: RTL and testbench
=====================================

# star_result_writer

Downstream stage of the STAR softmax engine. Accepts the per-element 32-bit softmax quotients the engine emits during its sum/divide phase, packs each 16-element row into a ping-pong row buffer, and drains completed rows to the output memory through a write-request/ready handshake. Alongside the writes it reports the per-row argmax, and it flags `done` once every row has been written.

## Interface
- `ROW_LEN`, 16: elements per row; matches the engine input length.
- `NUM_ROWS`, 16: rows per frame.
- `DATA_W`, 32: result width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_data` holds a result this cycle. `in_data` is undefined/high-Z when `in_valid`=0.
- `in_data` in DATA_W: softmax quotient, unsigned.
- `out_req` out 1: write request to output memory.
- `out_ready` in 1: memory accepts the write. A write completes on `out_req`&`out_ready`.
- `out_addr_x` out 4: element index within the row.
- `out_addr_y` out 4: row index.
- `out_data` out DATA_W: value to write.
- `argmax_valid` out 1: one-cycle pulse.
- `argmax_idx` out 4: index of the row maximum.
- `argmax_row` out 4: row the maximum belongs to.
- `overflow` out 1: sticky; a sample was dropped.
- `done` out 1: all NUM_ROWS rows written; held until reset.

## Operation
- **Fill side**
  - Counters `fill_idx` (0..ROW_LEN-1), `fill_row` (0..NUM_ROWS-1) and `fill_bank`.
  - Each accepted `in_valid` stores `in_data` at `bank[fill_bank][fill_idx]` and increments `fill_idx`.
  - On the last element: mark the bank full, toggle `fill_bank`, clear `fill_idx`, increment `fill_row`.
- **Argmax**
  - Running max/index per row, compared unsigned.
  - A strictly-greater value replaces the held max, so ties keep the lowest index.
  - Re-seeded by element 0 of each row.
- **Drain FSM**
  - States: D_IDLE, D_WRITE, D_DONE.
  - D_IDLE → D_WRITE when a bank is full.
  - In D_WRITE, `out_req`=1 and `out_addr_x` steps 0..ROW_LEN-1, advancing only on handshake.
  - After the ROW_LEN-th handshake: clear the bank's full flag and increment `drain_row`.
    - If `drain_row` was NUM_ROWS-1 → D_DONE.
    - Else if the other bank is full → stay in D_WRITE.
    - Else → D_IDLE.
  - D_DONE is terminal until reset.
- **Boundaries**
  - `in_valid` targets a bank that is still full → sample dropped, `overflow` set, counters unchanged.
  - `in_valid` after NUM_ROWS rows filled → dropped, `overflow` set.
  - Fill completes a bank in the same cycle the drain frees the other bank → both take effect; no lost row.
  - `out_ready` low → `out_addr_x`, `out_addr_y`, `out_data` held stable, `out_req` stays high.
  - `reset` mid-row or mid-drain → all counters, flags, banks and outputs return to reset values next edge; partial rows are discarded.
- **Reset values**: `out_req`=0, `out_addr_x`=0, `out_addr_y`=0, `out_data`=0, `argmax_valid`=0, `argmax_idx`=0, `argmax_row`=0, `overflow`=0, `done`=0.

## Timing
- Store latency: `in_data` is registered on the accepting edge.
- `argmax_valid` pulses the cycle after the last element of a row is accepted; `argmax_idx`/`argmax_row` are valid with it and hold until the next pulse.
- `out_req` rises the cycle after a bank becomes full, if the drain is idle.
- Address and data are registered outputs that change only the cycle after a handshake.
- Full-rate drain of one row takes ROW_LEN cycles. With `out_ready` held 1 the upstream never overflows, because the engine produces at most one element per cycle.
- `done` rises the cycle after the final handshake of row NUM_ROWS-1.

## Structure
- Shared package `star_pkg` holds:
  - `STAR_ROW_LEN`, `STAR_NUM_ROWS`, `STAR_DATA_W`
  - the `drain_state_t` enum (D_IDLE, D_WRITE, D_DONE)
  - index typedefs sized by `$clog2`.
- Sub-module `star_argmax_track`: running max/index with seed, compare and pulse generation.
- Bank storage and both FSMs live in the top.

## Test plan
- **Single row, ready=1**: values 16 down to 1 → writes (x=0..15, y=0) of 16..1 on consecutive cycles; argmax_idx=0, argmax_row=0.
- **Tie**: 5 at x=3 and x=9, all others 0 → argmax_idx=3.
- **Backpressure**: `out_ready` toggles 1,0,0,1 → each address/data pair held while ready=0; 16 handshakes total; no overflow.
- **Ping-pong overflow**: `out_ready`=0 while 3 rows are streamed → rows 0 and 1 stored; first element of row 2 dropped and `overflow`=1.
- **Full frame**: 16 rows of 16 back-to-back with ready=1 → 256 ordered writes; `done`=1 one cycle after the last handshake, held.
- **Mid-drain reset**: reset asserted at row 2, x=7 → next cycle all outputs zero; a new row then writes to y=0.

Source files
------------

// File: rtl/star_pkg.sv
// Shared definitions for the STAR softmax result path.
// Holds the default row geometry, the drain FSM state type and index types
// sized from that geometry.
package star_pkg;

   localparam int unsigned STAR_ROW_LEN  = 16;
   localparam int unsigned STAR_NUM_ROWS = 16;
   localparam int unsigned STAR_DATA_W   = 32;

   localparam int unsigned STAR_IDX_W = $clog2(STAR_ROW_LEN);
   localparam int unsigned STAR_ROW_W = $clog2(STAR_NUM_ROWS);

   typedef logic [STAR_IDX_W-1:0] elem_idx_t;
   typedef logic [STAR_ROW_W-1:0] row_idx_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_WRITE,
      D_DONE
   } drain_state_t;

endpackage

// File: rtl/star_argmax_track.sv
// Running per-row argmax of the accepted softmax quotients.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   sample_valid        a sample is accepted this cycle
//   sample_idx/row/data position and value of that sample
//   argmax_valid        one-cycle pulse after the last element of a row
//   argmax_idx/row      winning index and its row, held until the next pulse
module star_argmax_track
   import star_pkg::*;
#(
   parameter int unsigned DATA_W   = STAR_DATA_W,
   parameter int unsigned ROW_LEN  = STAR_ROW_LEN,
   parameter int unsigned NUM_ROWS = STAR_NUM_ROWS,
   localparam int unsigned IDX_W   = $clog2(ROW_LEN),
   localparam int unsigned ROW_W   = $clog2(NUM_ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [IDX_W-1:0]  sample_idx,
   input  logic [ROW_W-1:0]  sample_row,
   input  logic [DATA_W-1:0] sample_data,
   output logic              argmax_valid,
   output logic [IDX_W-1:0]  argmax_idx,
   output logic [ROW_W-1:0]  argmax_row
);

   logic [DATA_W-1:0] max_q, max_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              take;
   logic              valid_q;
   logic [IDX_W-1:0]  out_idx_q;
   logic [ROW_W-1:0]  out_row_q;

   // Element 0 reseeds; later elements win only when strictly greater, so
   // ties keep the lowest index.
   always_comb begin
      take  = (sample_idx == '0) || (sample_data > max_q);
      max_d = take ? sample_data : max_q;
      idx_d = take ? sample_idx : idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         max_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         out_idx_q <= '0;
         out_row_q <= '0;
      end else begin
         valid_q <= 1'b0;
         if (sample_valid) begin
            max_q <= max_d;
            idx_q <= idx_d;
            if (sample_idx == IDX_W'(ROW_LEN - 1)) begin
               valid_q   <= 1'b1;
               out_idx_q <= idx_d;
               out_row_q <= sample_row;
            end
         end
      end
   end

   assign argmax_valid = valid_q;
   assign argmax_idx   = out_idx_q;
   assign argmax_row   = out_row_q;

endmodule

// File: rtl/star_result_writer.sv
// Result writer for the STAR softmax engine.
// Packs incoming quotients into a two-bank row buffer and drains finished rows
// to the output memory over a req/ready handshake, reporting each row's argmax.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid, in_data              one quotient per valid cycle
//   out_req, out_ready             write handshake, completes on req & ready
//   out_addr_x, out_addr_y, out_data  registered write address and data
//   argmax_valid/idx/row           per-row argmax pulse and result
//   overflow                       sticky: a sample was dropped
//   done                           every row written, held until reset
module star_result_writer
   import star_pkg::*;
#(
   parameter int unsigned ROW_LEN  = STAR_ROW_LEN,
   parameter int unsigned NUM_ROWS = STAR_NUM_ROWS,
   parameter int unsigned DATA_W   = STAR_DATA_W,
   localparam int unsigned IDX_W   = $clog2(ROW_LEN),
   localparam int unsigned ROW_W   = $clog2(NUM_ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_req,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_addr_x,
   output logic [ROW_W-1:0]  out_addr_y,
   output logic [DATA_W-1:0] out_data,
   output logic              argmax_valid,
   output logic [IDX_W-1:0]  argmax_idx,
   output logic [ROW_W-1:0]  argmax_row,
   output logic              overflow,
   output logic              done
);

   logic [DATA_W-1:0] bank_q [2][ROW_LEN];
   logic [1:0]        full_q, full_d, bank_ready;

   logic              fill_bank_q;
   logic [IDX_W-1:0]  fill_idx_q;
   logic [ROW_W-1:0]  fill_row_q;
   logic              fill_done_q;
   logic              overflow_q;
   logic              accept, fill_last, row_complete;

   drain_state_t      state_q, state_d;
   logic              drain_bank_q, drain_bank_d;
   logic [IDX_W-1:0]  drain_x_q, drain_x_d;
   logic [ROW_W-1:0]  drain_row_q, drain_row_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              drain_free;

   assign fill_last    = (fill_idx_q == IDX_W'(ROW_LEN - 1));
   assign accept       = in_valid & ~fill_done_q & ~full_q[fill_bank_q];
   assign row_complete = accept & fill_last;

   // A bank counts as ready in the cycle its last element arrives; element 0
   // is already stored, so the drain can start without a bubble. This keeps a
   // full-rate drain ahead of a full-rate fill.
   always_comb begin
      bank_ready = full_q;
      if (row_complete) begin
         bank_ready[fill_bank_q] = 1'b1;
      end
      full_d = bank_ready;
      if (drain_free) begin
         full_d[drain_bank_q] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < int'(ROW_LEN); i++) begin
               bank_q[b][i] <= '0;
            end
         end
         full_q      <= '0;
         fill_bank_q <= 1'b0;
         fill_idx_q  <= '0;
         fill_row_q  <= '0;
         fill_done_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         full_q <= full_d;
         if (accept) begin
            bank_q[fill_bank_q][fill_idx_q] <= in_data;
            if (fill_last) begin
               fill_idx_q  <= '0;
               fill_bank_q <= ~fill_bank_q;
               fill_row_q  <= fill_row_q + 1'b1;
               if (fill_row_q == ROW_W'(NUM_ROWS - 1)) begin
                  fill_done_q <= 1'b1;
               end
            end else begin
               fill_idx_q <= fill_idx_q + 1'b1;
            end
         end
         if (in_valid && !accept) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      drain_bank_d = drain_bank_q;
      drain_x_d    = drain_x_q;
      drain_row_d  = drain_row_q;
      out_data_d   = out_data_q;
      drain_free   = 1'b0;
      unique case (state_q)
         D_IDLE: begin
            if (bank_ready[drain_bank_q]) begin
               state_d    = D_WRITE;
               drain_x_d  = '0;
               out_data_d = bank_q[drain_bank_q][0];
            end
         end
         D_WRITE: begin
            if (out_ready) begin
               if (drain_x_q == IDX_W'(ROW_LEN - 1)) begin
                  drain_free   = 1'b1;
                  drain_x_d    = '0;
                  drain_bank_d = ~drain_bank_q;
                  drain_row_d  = drain_row_q + 1'b1;
                  if (drain_row_q == ROW_W'(NUM_ROWS - 1)) begin
                     state_d = D_DONE;
                  end else if (bank_ready[~drain_bank_q]) begin
                     out_data_d = bank_q[~drain_bank_q][0];
                  end else begin
                     state_d = D_IDLE;
                  end
               end else begin
                  drain_x_d  = drain_x_q + 1'b1;
                  out_data_d = bank_q[drain_bank_q][drain_x_q + 1'b1];
               end
            end
         end
         D_DONE: begin
         end
         default: state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= D_IDLE;
         drain_bank_q <= 1'b0;
         drain_x_q    <= '0;
         drain_row_q  <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         drain_bank_q <= drain_bank_d;
         drain_x_q    <= drain_x_d;
         drain_row_q  <= drain_row_d;
         out_data_q   <= out_data_d;
      end
   end

   star_argmax_track #(
      .DATA_W   (DATA_W),
      .ROW_LEN  (ROW_LEN),
      .NUM_ROWS (NUM_ROWS)
   ) u_argmax (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (accept),
      .sample_idx   (fill_idx_q),
      .sample_row   (fill_row_q),
      .sample_data  (in_data),
      .argmax_valid (argmax_valid),
      .argmax_idx   (argmax_idx),
      .argmax_row   (argmax_row)
   );

   assign out_req    = (state_q == D_WRITE);
   assign out_addr_x = drain_x_q;
   assign out_addr_y = drain_row_q;
   assign out_data   = out_data_q;
   assign overflow   = overflow_q;
   assign done       = (state_q == D_DONE);

endmodule

// File: tb/tb_star_result_writer.sv
module tb_star_result_writer;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic        out_req, argmax_valid, overflow, done;
   logic [3:0]  out_addr_x, out_addr_y, argmax_idx, argmax_row;

   typedef struct {
      logic [3:0]  x;
      logic [3:0]  y;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [3:0] idx;
      logic [3:0] row;
   } am_t;

   wr_t exp_q[$];
   wr_t obs_q[$];
   am_t exp_am[$];
   am_t am_q[$];

   logic [31:0] row_vals [16];
   int          tb_row;
   int          cyc = 0;
   int          done_cyc = -1;
   int          errors = 0;
   int          checks = 0;

   star_result_writer dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .out_req      (out_req),
      .out_ready    (out_ready),
      .out_addr_x   (out_addr_x),
      .out_addr_y   (out_addr_y),
      .out_data     (out_data),
      .argmax_valid (argmax_valid),
      .argmax_idx   (argmax_idx),
      .argmax_row   (argmax_row),
      .overflow     (overflow),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Recorder only: captures handshakes and argmax pulses for the tests.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_req && out_ready) obs_q.push_back('{out_addr_x, out_addr_y, out_data, cyc});
         if (argmax_valid) am_q.push_back('{argmax_idx, argmax_row});
         if (done && done_cyc < 0) done_cyc = cyc;
      end
   end

   task automatic apply_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete(); obs_q.delete(); exp_am.delete(); am_q.delete();
      done_cyc = -1;
      tb_row   = 0;
   endtask

   // Streams row_vals back to back; when accepted, pushes the expected writes
   // and the expected argmax for the row.
   task automatic send_row(input bit accepted);
      int best;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = row_vals[i];
         if (accepted) exp_q.push_back('{4'(i), 4'(tb_row), row_vals[i], 0});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      if (accepted) begin
         best = 0;
         for (int i = 1; i < 16; i++) if (row_vals[i] > row_vals[best]) best = i;
         exp_am.push_back('{4'(best), 4'(tb_row)});
         tb_row++;
      end
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (obs_q.size() >= n) ok = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({out_req, out_addr_x, out_addr_y, out_data} !== 41'd0) begin
         errors++;
         $display("FAIL reset_write_port: got req=%b x=%0d y=%0d d=%h, want all 0",
                  out_req, out_addr_x, out_addr_y, out_data);
      end
      checks++;
      if ({argmax_valid, argmax_idx, argmax_row, overflow, done} !== 11'd0) begin
         errors++;
         $display("FAIL reset_status: got amv=%b idx=%0d row=%0d ovf=%b done=%b, want all 0",
                  argmax_valid, argmax_idx, argmax_row, overflow, done);
      end
   endtask

   task automatic test_single_row();
      bit ok;
      wr_t e, o;
      int prev;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) row_vals[i] = 32'(16 - i);
      send_row(1'b1);
      checks++;
      if ({argmax_valid, argmax_idx, argmax_row} !== {1'b1, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL single_argmax: got v=%b idx=%0d row=%0d, want v=1 idx=0 row=0",
                  argmax_valid, argmax_idx, argmax_row);
      end
      @(posedge clk); #1;
      checks++;
      if (argmax_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_argmax_pulse: got %b, want 0", argmax_valid);
      end
      wait_obs(16, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout: got %0d writes, want 16", obs_q.size());
      end
      prev = -1;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.x !== e.x || o.y !== e.y || o.data !== e.data || (prev >= 0 && o.cyc != prev + 1)) begin
            errors++;
            $display("FAIL single_write: got x=%0d y=%0d d=%0d cyc=%0d, want x=%0d y=%0d d=%0d cyc=%0d",
                     o.x, o.y, o.data, o.cyc, e.x, e.y, e.data, prev + 1);
         end
         prev = o.cyc;
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_req, done, overflow} !== 3'b000) begin
         errors++;
         $display("FAIL single_idle: got req=%b done=%b ovf=%b, want 0 0 0", out_req, done, overflow);
      end
   endtask

   task automatic test_tie();
      bit ok;
      wr_t e, o;
      for (int i = 0; i < 16; i++) row_vals[i] = '0;
      row_vals[3] = 32'd5;
      row_vals[9] = 32'd5;
      send_row(1'b1);
      checks++;
      if ({argmax_valid, argmax_idx, argmax_row} !== {1'b1, 4'd3, 4'd1}) begin
         errors++;
         $display("FAIL tie_argmax: got v=%b idx=%0d row=%0d, want v=1 idx=3 row=1",
                  argmax_valid, argmax_idx, argmax_row);
      end
      wait_obs(16, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tie_timeout: got %0d writes, want 16", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.x !== e.x || o.y !== e.y || o.data !== e.data) begin
            errors++;
            $display("FAIL tie_write: got x=%0d y=%0d d=%0d, want x=%0d y=%0d d=%0d",
                     o.x, o.y, o.data, e.x, e.y, e.data);
         end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic [3:0]  pat = 4'b1001;
      bit          stalled = 1'b0;
      logic [3:0]  sx, sy;
      logic [31:0] sd;
      wr_t         e, o;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) row_vals[i] = $urandom;
      send_row(1'b1);
      for (int i = 0; i < 200 && obs_q.size() < 16; i++) begin
         out_ready = pat[i % 4];
         @(negedge clk);
         if (stalled) begin
            checks++;
            if ({out_req, out_addr_x, out_addr_y, out_data} !== {1'b1, sx, sy, sd}) begin
               errors++;
               $display("FAIL bp_hold: got req=%b x=%0d y=%0d d=%h, want req=1 x=%0d y=%0d d=%h",
                        out_req, out_addr_x, out_addr_y, out_data, sx, sy, sd);
            end
         end
         stalled = out_req && !out_ready;
         sx = out_addr_x;
         sy = out_addr_y;
         sd = out_data;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != 16 || exp_q.size() != 16) begin
         errors++;
         $display("FAIL bp_count: got %0d handshakes, want 16", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.x !== e.x || o.y !== e.y || o.data !== e.data) begin
            errors++;
            $display("FAIL bp_write: got x=%0d y=%0d d=%h, want x=%0d y=%0d d=%h",
                     o.x, o.y, o.data, e.x, e.y, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL bp_overflow: got %b, want 0", overflow);
      end
   endtask

   task automatic test_pingpong_overflow();
      bit  ok;
      wr_t e, o;
      out_ready = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) row_vals[i] = $urandom;
         send_row(1'b1);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL pp_overflow_early: got %b, want 0", overflow);
      end
      for (int i = 0; i < 16; i++) row_vals[i] = $urandom;
      send_row(1'b0);
      checks++;
      if ({overflow, out_req, out_addr_y, out_addr_x} !== {1'b1, 1'b1, 4'd3, 4'd0}) begin
         errors++;
         $display("FAIL pp_overflow: got ovf=%b req=%b y=%0d x=%0d, want ovf=1 req=1 y=3 x=0",
                  overflow, out_req, out_addr_y, out_addr_x);
      end
      out_ready = 1'b1;
      wait_obs(32, 150, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL pp_timeout: got %0d writes, want 32", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.x !== e.x || o.y !== e.y || o.data !== e.data) begin
            errors++;
            $display("FAIL pp_write: got x=%0d y=%0d d=%h, want x=%0d y=%0d d=%h",
                     o.x, o.y, o.data, e.x, e.y, e.data);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (overflow !== 1'b1 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL pp_sticky: got ovf=%b extra=%0d, want ovf=1 extra=0", overflow, obs_q.size());
      end
   endtask

   task automatic test_full_frame();
      bit  ok;
      wr_t e, o;
      am_t ea, oa;
      int  last_cyc = -1;
      apply_reset();
      out_ready = 1'b1;
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < 16; i++) row_vals[i] = $urandom_range(0, 40);
         send_row(1'b1);
      end
      wait_obs(256, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL frame_timeout: got %0d writes, want 256", obs_q.size());
      end
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (obs_q.size() != 256) begin
         errors++;
         $display("FAIL frame_count: got %0d writes, want 256", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         last_cyc = o.cyc;
         checks++;
         if (o.x !== e.x || o.y !== e.y || o.data !== e.data) begin
            errors++;
            $display("FAIL frame_write: got x=%0d y=%0d d=%0d, want x=%0d y=%0d d=%0d",
                     o.x, o.y, o.data, e.x, e.y, e.data);
         end
      end
      checks++;
      if (done_cyc != last_cyc + 1 || done !== 1'b1) begin
         errors++;
         $display("FAIL frame_done_timing: got done=%b at cyc %0d, want done=1 at cyc %0d",
                  done, done_cyc, last_cyc + 1);
      end
      checks++;
      if (am_q.size() != 16) begin
         errors++;
         $display("FAIL frame_argmax_count: got %0d pulses, want 16", am_q.size());
      end
      while (exp_am.size() > 0 && am_q.size() > 0) begin
         ea = exp_am.pop_front();
         oa = am_q.pop_front();
         checks++;
         if (oa.idx !== ea.idx || oa.row !== ea.row) begin
            errors++;
            $display("FAIL frame_argmax: got idx=%0d row=%0d, want idx=%0d row=%0d",
                     oa.idx, oa.row, ea.idx, ea.row);
         end
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({done, out_req, overflow} !== 3'b100) begin
         errors++;
         $display("FAIL frame_done_held: got done=%b req=%b ovf=%b, want 1 0 0", done, out_req, overflow);
      end
   endtask

   task automatic test_mid_drain_reset();
      bit  ok, hit = 1'b0;
      wr_t e, o;
      apply_reset();
      out_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) row_vals[i] = $urandom;
         send_row(1'b1);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_req && out_addr_y == 4'd2 && out_addr_x == 4'd7) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mdr_reach: got y=%0d x=%0d, want y=2 x=7", out_addr_y, out_addr_x);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_req, out_addr_x, out_addr_y, out_data, argmax_valid, argmax_idx, argmax_row,
           overflow, done} !== 52'd0) begin
         errors++;
         $display("FAIL mdr_outputs: got req=%b x=%0d y=%0d d=%h amv=%b ovf=%b done=%b, want all 0",
                  out_req, out_addr_x, out_addr_y, out_data, argmax_valid, overflow, done);
      end
      reset = 1'b0;
      exp_q.delete(); obs_q.delete(); exp_am.delete(); am_q.delete();
      tb_row = 0;
      for (int i = 0; i < 16; i++) row_vals[i] = 32'h100 + 32'(i);
      send_row(1'b1);
      wait_obs(16, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mdr_timeout: got %0d writes, want 16", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.x !== e.x || o.y !== e.y || o.data !== e.data) begin
            errors++;
            $display("FAIL mdr_write: got x=%0d y=%0d d=%h, want x=%0d y=%0d d=%h",
                     o.x, o.y, o.data, e.x, e.y, e.data);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tb_row    = 0;
      test_reset();
      test_single_row();
      test_tie();
      test_backpressure();
      test_pingpong_overflow();
      test_full_frame();
      test_mid_drain_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
